// File: rtl/ps2_kbd_ctrl.sv
// rtl/ps2_kbd_ctrl.sv - PS/2 set-2 scan-code sequencer between receiver FIFO and key-event consumers
// Pops bytes at most once per three cycles, folds E0/F0/E1 prefixes and emits one event per scan code.
module ps2_kbd_ctrl #(
  parameter int CNT_W      = 8,
  parameter int PAUSE_SKIP = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_ready,
  input  logic [7:0]       rx_data,
  input  logic             rx_overflow,
  output logic             rx_nextdata_n,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_break,
  output logic             key_down,
  output logic [7:0]       held_code,
  output logic             held_ext,
  output logic [CNT_W-1:0] press_cnt,
  output logic             err_ovf,
  input  logic             err_clr
);

  localparam int SKIP_W = (PAUSE_SKIP < 1) ? 1 : $clog2(PAUSE_SKIP + 1);

  typedef enum logic [1:0] {IDLE, POP, GAP} state_t;

  state_t             state_q, state_d;
  logic               pop;
  logic               ext_f_q, ext_f_d;
  logic               brk_f_q, brk_f_d;
  logic [SKIP_W-1:0]  skip_cnt_q, skip_cnt_d;
  logic               evt_valid_q, evt_valid_d;
  logic [7:0]         evt_code_q, evt_code_d;
  logic               evt_ext_q, evt_ext_d;
  logic               evt_break_q, evt_break_d;
  logic               key_down_q, key_down_d;
  logic [7:0]         held_code_q, held_code_d;
  logic               held_ext_q, held_ext_d;
  logic [CNT_W-1:0]   press_cnt_q, press_cnt_d;
  logic               err_ovf_q, err_ovf_d;
  logic               emit, emit_pause, emit_ext, emit_brk;
  logic [7:0]         emit_code;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rx_ready && (!evt_valid_q || evt_ready)) state_d = POP;
      POP:     state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop           = (state_q == POP);
    rx_nextdata_n = !pop;
  end

  // Byte decode: an active Pause skip swallows everything, including prefixes.
  always_comb begin
    skip_cnt_d = skip_cnt_q;
    ext_f_d    = ext_f_q;
    brk_f_d    = brk_f_q;
    emit       = 1'b0;
    emit_pause = 1'b0;
    emit_code  = rx_data;
    emit_ext   = ext_f_q;
    emit_brk   = brk_f_q;
    if (pop) begin
      if (skip_cnt_q != '0) begin
        skip_cnt_d = skip_cnt_q - 1'b1;
        if (skip_cnt_q == SKIP_W'(1)) begin
          emit       = 1'b1;
          emit_pause = 1'b1;
          emit_code  = 8'h77;
          emit_ext   = 1'b1;
          emit_brk   = 1'b0;
        end
      end else if (rx_data == 8'hE1) begin
        skip_cnt_d = SKIP_W'(PAUSE_SKIP);
      end else if (rx_data == 8'hE0) begin
        ext_f_d = 1'b1;
      end else if (rx_data == 8'hF0) begin
        brk_f_d = 1'b1;
      end else begin
        emit    = 1'b1;
        ext_f_d = 1'b0;
        brk_f_d = 1'b0;
      end
    end
  end

  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_code_d  = evt_code_q;
    evt_ext_d   = evt_ext_q;
    evt_break_d = evt_break_q;
    if (evt_valid_q && evt_ready) evt_valid_d = 1'b0;
    if (emit) begin
      evt_valid_d = 1'b1;
      evt_code_d  = emit_code;
      evt_ext_d   = emit_ext;
      evt_break_d = emit_brk;
    end
  end

  // Typematic repeats of the held key neither re-latch nor count.
  always_comb begin
    key_down_d  = key_down_q;
    held_code_d = held_code_q;
    held_ext_d  = held_ext_q;
    press_cnt_d = press_cnt_q;
    if (emit && !emit_pause) begin
      if (!emit_brk) begin
        if (!(key_down_q && emit_code == held_code_q && emit_ext == held_ext_q)) begin
          key_down_d  = 1'b1;
          held_code_d = emit_code;
          held_ext_d  = emit_ext;
          press_cnt_d = press_cnt_q + 1'b1;
        end
      end else if (emit_code == held_code_q && emit_ext == held_ext_q) begin
        key_down_d = 1'b0;
      end
    end
  end

  always_comb begin
    err_ovf_d = err_ovf_q;
    if (rx_overflow)  err_ovf_d = 1'b1;
    else if (err_clr) err_ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_f_q     <= 1'b0;
      brk_f_q     <= 1'b0;
      skip_cnt_q  <= '0;
      evt_valid_q <= 1'b0;
      evt_code_q  <= 8'h00;
      evt_ext_q   <= 1'b0;
      evt_break_q <= 1'b0;
      key_down_q  <= 1'b0;
      held_code_q <= 8'h00;
      held_ext_q  <= 1'b0;
      press_cnt_q <= '0;
      err_ovf_q   <= 1'b0;
    end else begin
      ext_f_q     <= ext_f_d;
      brk_f_q     <= brk_f_d;
      skip_cnt_q  <= skip_cnt_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      evt_ext_q   <= evt_ext_d;
      evt_break_q <= evt_break_d;
      key_down_q  <= key_down_d;
      held_code_q <= held_code_d;
      held_ext_q  <= held_ext_d;
      press_cnt_q <= press_cnt_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_code  = evt_code_q;
  assign evt_ext   = evt_ext_q;
  assign evt_break = evt_break_q;
  assign key_down  = key_down_q;
  assign held_code = held_code_q;
  assign held_ext  = held_ext_q;
  assign press_cnt = press_cnt_q;
  assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb/tb_ps2_kbd_ctrl.sv - scoreboard bench for ps2_kbd_ctrl with a behavioural receiver FIFO
module tb_ps2_kbd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_overflow;
  logic       rx_nextdata_n;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic       key_down;
  logic [7:0] held_code;
  logic       held_ext;
  logic [7:0] press_cnt;
  logic       err_ovf;
  logic       err_clr;

  ps2_kbd_ctrl #(.CNT_W(8), .PAUSE_SKIP(7)) dut (
    .clk(clk), .rst(rst), .rx_ready(rx_ready), .rx_data(rx_data),
    .rx_overflow(rx_overflow), .rx_nextdata_n(rx_nextdata_n),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code),
    .evt_ext(evt_ext), .evt_break(evt_break), .key_down(key_down),
    .held_code(held_code), .held_ext(held_ext), .press_cnt(press_cnt),
    .err_ovf(err_ovf), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       kd;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fifo[$];
  logic       pop_req = 1'b0;
  int         total = 0;
  int         bad = 0;
  int         pops = 0;
  int         cyc = 0;
  int         last_pop = -100;
  logic       prev_low = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo.push_back(b);
  endtask

  task automatic expect_evt(input logic [7:0] code, input logic ext, input logic brk, input logic kd);
    exp_t e;
    e.code = code; e.ext = ext; e.brk = brk; e.kd = kd;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((fifo.size() != 0 || exp_q.size() != 0 || evt_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", 32'(n < 3000), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  // Receiver FIFO model: a pop seen during POP takes effect after the sampling edge.
  always @(negedge clk) begin
    if (rst) begin
      pop_req = 1'b0;
    end else begin
      if (pop_req && fifo.size() != 0) void'(fifo.pop_front());
      pop_req = !rx_nextdata_n;
    end
    rx_ready = (fifo.size() != 0);
    rx_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
  end

  // Monitor: pop-strobe shape and scoreboard comparison on each accepted event.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (rst) begin
        prev_low = 1'b0;
        last_pop = -100;
      end else begin
        if (!rx_nextdata_n) begin
          check("pop_not_back_to_back", 32'(prev_low), 32'd0);
          check("pop_spacing_ge3", 32'(cyc - last_pop >= 3), 32'd1);
          last_pop = cyc;
          pops++;
        end
        prev_low = !rx_nextdata_n;
        if (evt_valid && evt_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event actual=%0h required=none", {evt_code, evt_ext, evt_break});
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("evt_fields", {20'd0, evt_code, evt_ext, evt_break, key_down},
                  {20'd0, e.code, e.ext, e.brk, e.kd});
          end
        end
      end
    end
  end

  initial begin
    int base;
    int n;
    rst = 1'b1; rx_overflow = 1'b0; err_clr = 1'b0; evt_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_nextdata_n", 32'(rx_nextdata_n), 32'd1);
    check("rst_outputs", {16'd0, evt_valid, evt_code, evt_ext, evt_break, key_down, held_code, held_ext, err_ovf},
          32'd0);
    check("rst_press_cnt", 32'(press_cnt), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Make/break of 1C
    base = pops;
    push_byte(8'h1C); push_byte(8'hF0); push_byte(8'h1C);
    expect_evt(8'h1C, 0, 0, 1);
    expect_evt(8'h1C, 0, 1, 0);
    wait_drain();
    check("t1_press_cnt", 32'(press_cnt), 32'd1);
    check("t1_key_down", 32'(key_down), 32'd0);
    check("t1_held_code", 32'(held_code), 32'h1C);
    check("t1_pop_count", 32'(pops - base), 32'd3);

    // Extended key with prefixes in both orders
    push_byte(8'hE0); push_byte(8'h75); push_byte(8'hE0); push_byte(8'hF0); push_byte(8'h75);
    expect_evt(8'h75, 1, 0, 1);
    expect_evt(8'h75, 1, 1, 0);
    wait_drain();
    check("t2_held_ext", 32'(held_ext), 32'd1);
    check("t2_press_cnt", 32'(press_cnt), 32'd2);

    // Typematic repeat then a new key
    push_byte(8'h1C); push_byte(8'h1C); push_byte(8'h1C); push_byte(8'h32);
    expect_evt(8'h1C, 0, 0, 1);
    expect_evt(8'h1C, 0, 0, 1);
    expect_evt(8'h1C, 0, 0, 1);
    expect_evt(8'h32, 0, 0, 1);
    wait_drain();
    check("t3_press_cnt", 32'(press_cnt), 32'd4);
    check("t3_held_code", 32'(held_code), 32'h32);

    // Pause sequence collapses to one event and leaves held state alone
    push_byte(8'hE1); push_byte(8'h14); push_byte(8'h77); push_byte(8'hE1);
    push_byte(8'hF0); push_byte(8'h14); push_byte(8'hF0); push_byte(8'h77);
    expect_evt(8'h77, 1, 0, 1);
    wait_drain();
    check("t4_press_cnt", 32'(press_cnt), 32'd4);
    check("t4_held_code", 32'(held_code), 32'h32);
    push_byte(8'hF0); push_byte(8'h32);
    expect_evt(8'h32, 0, 1, 0);
    wait_drain();
    check("t4_release_key_down", 32'(key_down), 32'd0);

    // Backpressure
    evt_ready = 1'b0;
    push_byte(8'h1A); push_byte(8'h1B); push_byte(8'h1C);
    expect_evt(8'h1A, 0, 0, 1);
    expect_evt(8'h1B, 0, 0, 1);
    expect_evt(8'h1C, 0, 0, 1);
    repeat (20) @(negedge clk);
    #1;
    check("t5_stall_valid", 32'(evt_valid), 32'd1);
    check("t5_stall_code", 32'(evt_code), 32'h1A);
    check("t5_stall_fifo", 32'(fifo.size()), 32'd2);
    repeat (5) @(negedge clk);
    #1;
    check("t5_stall_code_hold", 32'(evt_code), 32'h1A);
    check("t5_stall_fifo_hold", 32'(fifo.size()), 32'd2);
    @(negedge clk);
    evt_ready = 1'b1;
    wait_drain();
    check("t5_press_cnt", 32'(press_cnt), 32'd7);

    // 249 more distinct presses wrap the counter 7 -> 0
    for (int i = 0; i < 249; i++) begin
      push_byte((i % 2 == 0) ? 8'h15 : 8'h16);
      expect_evt((i % 2 == 0) ? 8'h15 : 8'h16, 0, 0, 1);
    end
    wait_drain();
    check("t6_press_wrap", 32'(press_cnt), 32'd0);
    check("t6_held_code", 32'(held_code), 32'h15);

    // Sticky overflow
    rx_overflow = 1'b1;
    @(negedge clk);
    rx_overflow = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("t7_ovf_sticky", 32'(err_ovf), 32'd1);
    rx_overflow = 1'b1; err_clr = 1'b1;
    @(negedge clk);
    #1;
    check("t7_set_wins", 32'(err_ovf), 32'd1);
    rx_overflow = 1'b0;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    check("t7_cleared", 32'(err_ovf), 32'd0);
    rx_overflow = 1'b1;
    @(negedge clk);
    rx_overflow = 1'b0;

    // Asynchronous reset while in POP
    push_byte(8'h2B);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (rx_nextdata_n && n < 50);
    check("t8_reached_pop", 32'(n < 50), 32'd1);
    rst = 1'b1;
    #1;
    check("t8_nextdata_n", 32'(rx_nextdata_n), 32'd1);
    check("t8_outputs", {16'd0, evt_valid, evt_code, evt_ext, evt_break, key_down, held_code, held_ext, err_ovf},
          32'd0);
    check("t8_press_cnt", 32'(press_cnt), 32'd0);
    fifo.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("t8_post_reset_idle", 32'(evt_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
